mmio_sw_input: RTL and testbench



---
 rtl/mmio_sw_input_if.sv | 28 ++
 rtl/mmio_sw_input.sv | 105 ++++++++++
 tb/tb_mmio_sw_input.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_sw_input_if.sv
// CPU-side MIO bus slice for the switch-input peripheral: select, write strobe,
// word offset, write data, combinational read data and level interrupt.
interface mmio_sw_input_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/mmio_sw_input.sv
// Memory-mapped switch/button input: 2-flop sync, tick-sampled debounce, sticky
// rising-edge flags with W1C, interrupt enable mask and level interrupt.
module mmio_sw_input #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned SAMPLES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    mmio_sw_input_if.slave   bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_EDGE   = 2'd1;
    localparam logic [1:0] A_IRQ_EN = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [CNT_W-1:0]   r_cnt;
    logic [SAMPLES-1:0] r_hist [WIDTH];
    logic [WIDTH-1:0]   r_db;
    logic [WIDTH-1:0]   r_edge;
    logic [WIDTH-1:0]   r_irq_en;

    logic               w_tick;
    logic [SAMPLES-1:0] w_hist_nxt [WIDTH];
    logic [WIDTH-1:0]   w_db_nxt;
    logic [WIDTH-1:0]   w_rise;
    logic               w_wr_edge;
    logic               w_wr_irq_en;
    logic [WIDTH-1:0]   w_clr;
    logic               w_irq;
    logic               w_unused;

    assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    // History including the sample being shifted in decides the accept on the tick edge
    always_comb begin
        w_db_nxt = r_db;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_hist_nxt[i] = {r_hist[i][SAMPLES-2:0], r_sync2[i]};
            if (w_tick) begin
                if ((&w_hist_nxt[i]) && !r_db[i]) begin
                    w_db_nxt[i] = 1'b1;
                end else if (!(|w_hist_nxt[i]) && r_db[i]) begin
                    w_db_nxt[i] = 1'b0;
                end
            end
        end
    end

    assign w_rise      = w_db_nxt & ~r_db;
    assign w_wr_edge   = bus.sel & bus.we & (bus.addr == A_EDGE);
    assign w_wr_irq_en = bus.sel & bus.we & (bus.addr == A_IRQ_EN);
    assign w_clr       = w_wr_edge ? bus.wdata[WIDTH-1:0] : '0;
    assign w_irq       = |(r_edge & r_irq_en);
    assign w_unused    = &{1'b0, bus.wdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cnt    <= '0;
            r_db     <= '0;
            r_edge   <= '0;
            r_irq_en <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
            r_cnt   <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    r_hist[i] <= w_hist_nxt[i];
                end
            end
            r_db   <= w_db_nxt;
            // A rising edge in the same cycle as its W1C must survive
            r_edge <= (r_edge & ~w_clr) | w_rise;
            if (w_wr_irq_en) begin
                r_irq_en <= bus.wdata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            A_DATA:   bus.rdata = 32'(r_db);
            A_EDGE:   bus.rdata = 32'(r_edge);
            A_IRQ_EN: bus.rdata = 32'(r_irq_en);
            A_STATUS: bus.rdata = {30'b0, |r_db, w_irq};
            default:  bus.rdata = '0;
        endcase
    end

    assign bus.irq = w_irq;

endmodule

// File: tb/tb_mmio_sw_input.sv
// Directed bench for mmio_sw_input with TICK_DIV=4, SAMPLES=3, WIDTH=16.
module tb_mmio_sw_input;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned SAMPLES  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw_i;

    mmio_sw_input_if bus ();

    mmio_sw_input #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TICK_DIV),
        .SAMPLES (SAMPLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw_i(sw_i),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        checks++;
        assert (bus.rdata === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.rdata, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        checks++;
        assert (bus.irq === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.irq, exp);
        end
    endtask

    task automatic chk_flag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cyc(1);
        bus.sel   = 1'b0;
        bus.we    = 1'b0;
    endtask

    logic found;
    logic seen;

    initial begin
        rst       = 1'b1;
        sw_i      = '0;
        bus.sel   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 32'h0;

        // Reset state
        cyc(2);
        rst = 1'b0;
        chk("rst_data",   2'd0, 32'h0);
        chk("rst_edge",   2'd1, 32'h0);
        chk("rst_irq_en", 2'd2, 32'h0);
        chk("rst_status", 2'd3, 32'h0);
        chk_irq("rst_irq", 1'b0);
        wr(2'd0, 32'h0000_FFFF);
        chk("data_ro", 2'd0, 32'h0);

        // Debounce accept within 2 + SAMPLES*TICK_DIV = 14 cycles
        sw_i     = 16'h0001;
        bus.addr = 2'd0;
        found    = 1'b0;
        for (int n = 1; n <= 14 && !found; n++) begin
            cyc(1);
            if (bus.rdata === 32'h1) found = 1'b1;
        end
        chk_flag("deb_latency", found, 1'b1);
        chk("deb_edge",   2'd1, 32'h1);
        chk("deb_status", 2'd3, 32'h2);
        chk_irq("deb_irq_masked", 1'b0);
        wr(2'd2, 32'h1);
        chk_irq("deb_irq_en", 1'b1);
        chk("deb_status_irq", 2'd3, 32'h3);

        // Glitch of 6 cycles on bit 3 never reaches DB
        bus.addr = 2'd0;
        seen     = 1'b0;
        sw_i     = 16'h0009;
        repeat (6) begin
            cyc(1);
            if (bus.rdata[3] !== 1'b0) seen = 1'b1;
        end
        sw_i = 16'h0001;
        repeat (20) begin
            cyc(1);
            if (bus.rdata[3] !== 1'b0) seen = 1'b1;
        end
        chk_flag("glitch_db", seen, 1'b0);
        chk("glitch_edge", 2'd1, 32'h1);

        // W1C and interrupt masking
        sw_i = 16'h0003;
        cyc(16);
        chk("w1c_pre_data", 2'd0, 32'h3);
        chk("w1c_pre_edge", 2'd1, 32'h3);
        chk_irq("w1c_pre_irq", 1'b1);
        wr(2'd1, 32'h1);
        chk("w1c_edge", 2'd1, 32'h2);
        chk_irq("w1c_irq_drop", 1'b0);
        wr(2'd2, 32'h1);
        chk_irq("irq_en1_irq", 1'b0);
        wr(2'd2, 32'hFFFF_FFFF);
        chk("irq_en_trunc", 2'd2, 32'h0000_FFFF);
        chk_irq("irq_en_all", 1'b1);
        chk("status_all", 2'd3, 32'h3);
        bus.sel   = 1'b0;
        bus.we    = 1'b1;
        bus.addr  = 2'd2;
        bus.wdata = 32'h0;
        cyc(1);
        bus.we = 1'b0;
        chk("nosel_irq_en", 2'd2, 32'h0000_FFFF);
        wr(2'd2, 32'h1);
        chk_irq("irq_en_restore", 1'b0);

        // W1C of bit 2 held across its rising edge: set must win
        sw_i      = 16'h0007;
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 2'd1;
        bus.wdata = 32'h4;
        found     = 1'b0;
        for (int n = 1; n <= 16 && !found; n++) begin
            cyc(1);
            if (bus.rdata[2] === 1'b1) found = 1'b1;
        end
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        chk_flag("collide_set", found, 1'b1);
        chk("collide_edge", 2'd1, 32'h6);
        chk("collide_data", 2'd0, 32'h7);
        bus.sel   = 1'b0;
        bus.we    = 1'b1;
        bus.addr  = 2'd1;
        bus.wdata = 32'hFFFF;
        cyc(1);
        bus.we = 1'b0;
        chk("nosel_edge", 2'd1, 32'h6);

        // Reset after two ticks of partial history discards it
        rst  = 1'b1;
        cyc(1);
        rst  = 1'b0;
        sw_i = 16'h8000;
        cyc(8);
        chk("mid_pre_data", 2'd0, 32'h0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_data",   2'd0, 32'h0);
        chk("mid_edge",   2'd1, 32'h0);
        chk("mid_irq_en", 2'd2, 32'h0);
        chk_irq("mid_irq", 1'b0);
        cyc(11);
        chk("mid_early_data", 2'd0, 32'h0);
        cyc(1);
        chk("mid_late_data", 2'd0, 32'h8000);
        chk("mid_late_edge", 2'd1, 32'h8000);
        chk("mid_status",    2'd3, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
